// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encoding,
// default game parameters and the hold-timer width.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam int TIMER_W          = 7;
  localparam int START_LIVES_DEF  = 3;
  localparam int DELAY_FRAMES_DEF = 120;

endpackage

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD score counter, increments once per inc pulse and
// saturates at 99; clr has priority over inc.
module pong_bcd_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  logic [3:0] r_d1;
  logic [3:0] r_d0;
  logic       w_at_max;

  assign w_at_max = (r_d1 == 4'd9) && (r_d0 == 4'd9);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_d1 <= 4'd0;
      r_d0 <= 4'd0;
    end else if (inc && !w_at_max) begin
      if (r_d0 == 4'd9) begin
        r_d0 <= 4'd0;
        r_d1 <= r_d1 + 4'd1;
      end else begin
        r_d0 <= r_d0 + 4'd1;
      end
    end
  end

  assign d1 = r_d1;
  assign d0 = r_d0;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: edge-detected inputs, game FSM, lives counter,
// frame-based hold timer and BCD score.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int START_LIVES  = START_LIVES_DEF,
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] btn_left,
  input  logic [1:0] btn_right,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] lives,
  output logic       timer_busy
);

  localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DELAY_FRAMES);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_lives;
  logic [1:0]         w_lives_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               r_hit_p0;
  logic               r_miss_p0;
  logic               r_start_p0;
  logic               w_start;
  logic               w_hit_edge;
  logic               w_miss_edge;
  logic               w_start_edge;
  logic               w_clr;
  logic               w_inc;
  logic               w_timer_zero;

  assign w_start      = |{btn_left, btn_right};
  assign w_hit_edge   = hit && !r_hit_p0;
  assign w_miss_edge  = miss && !r_miss_p0;
  assign w_start_edge = w_start && !r_start_p0;
  assign w_timer_zero = (r_timer == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_NEWGAME;
      r_lives    <= LIVES_INIT;
      r_timer    <= '0;
      r_hit_p0   <= 1'b0;
      r_miss_p0  <= 1'b0;
      r_start_p0 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lives    <= w_lives_nxt;
      r_timer    <= w_timer_nxt;
      r_hit_p0   <= hit;
      r_miss_p0  <= miss;
      r_start_p0 <= w_start;
    end
  end

  // A miss edge wins over a simultaneous hit edge, so inc is only raised without one.
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_timer_nxt = r_timer;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    if (frame_tick && !w_timer_zero) w_timer_nxt = r_timer - TIMER_W'(1);
    case (r_state)
      ST_NEWGAME: begin
        if (w_start_edge) begin
          w_state_nxt = ST_PLAY;
          w_clr       = 1'b1;
          w_lives_nxt = LIVES_INIT;
        end
      end
      ST_PLAY: begin
        if (w_miss_edge) begin
          w_timer_nxt = TIMER_LOAD;
          if (r_lives > 2'd1) begin
            w_lives_nxt = r_lives - 2'd1;
            w_state_nxt = ST_NEWBALL;
          end else begin
            w_lives_nxt = 2'd0;
            w_state_nxt = ST_OVER;
          end
        end else if (w_hit_edge) begin
          w_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (w_start_edge && w_timer_zero) w_state_nxt = ST_PLAY;
      end
      ST_OVER: begin
        if (w_timer_zero) w_state_nxt = ST_NEWGAME;
      end
      default: w_state_nxt = ST_NEWGAME;
    endcase
  end

  pong_bcd_counter u_score (
    .clk (clk),
    .clr (reset || w_clr),
    .inc (w_inc),
    .d1  (score_d1),
    .d0  (score_d0)
  );

  assign game_state = r_state;
  assign gra_still  = (r_state != ST_PLAY);
  assign lives      = r_lives;
  assign timer_busy = !w_timer_zero;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int START_LIVES  = 3;
  localparam int DELAY_FRAMES = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] btn_left = 2'b00;
  logic [1:0] btn_right = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [1:0] game_state;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] lives;
  logic       timer_busy;

  int n_vec = 0;
  int n_err = 0;

  // model: mode 0=waiting for game, 1=playing, 2=serving new ball, 3=game over
  int m_mode, m_score, m_lives, m_timer;
  bit m_ph, m_pm, m_ps;

  pong_game_ctrl #(.START_LIVES(START_LIVES), .DELAY_FRAMES(DELAY_FRAMES)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .game_state (game_state),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .lives      (lives),
    .timer_busy (timer_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit h, input bit m, input bit s, input bit ft);
    bit he, me, se;
    int t0;
    if (r) begin
      m_mode = 0; m_score = 0; m_lives = START_LIVES; m_timer = 0;
      m_ph = 0; m_pm = 0; m_ps = 0;
      return;
    end
    he = h && !m_ph;
    me = m && !m_pm;
    se = s && !m_ps;
    m_ph = h; m_pm = m; m_ps = s;
    t0 = m_timer;
    if (ft && m_timer > 0) m_timer = m_timer - 1;
    if (m_mode == 0) begin
      if (se) begin m_mode = 1; m_score = 0; m_lives = START_LIVES; end
    end else if (m_mode == 1) begin
      if (me) begin
        m_timer = DELAY_FRAMES;
        m_lives = (m_lives > 1) ? m_lives - 1 : 0;
        m_mode  = (m_lives > 0) ? 2 : 3;
      end else if (he && m_score < 99) begin
        m_score = m_score + 1;
      end
    end else if (m_mode == 2) begin
      if (se && t0 == 0) m_mode = 1;
    end else begin
      if (t0 == 0) m_mode = 0;
    end
  endtask

  task automatic check_all();
    chk("game_state", 8'(game_state), 8'(m_mode));
    chk("gra_still",  8'(gra_still),  8'(m_mode != 1));
    chk("lives",      8'(lives),      8'(m_lives));
    chk("score_d1",   8'(score_d1),   8'(m_score / 10));
    chk("score_d0",   8'(score_d0),   8'(m_score % 10));
    chk("timer_busy", 8'(timer_busy), 8'(m_timer != 0));
  endtask

  task automatic cyc(input bit r, input bit h, input bit m, input logic [1:0] bl,
                     input logic [1:0] br, input bit ft);
    reset = r; hit = h; miss = m; btn_left = bl; btn_right = br; frame_tick = ft;
    @(posedge clk);
    model_step(r, h, m, |{bl, br}, ft);
    #1;
    check_all();
  endtask

  task automatic idle(); cyc(0, 0, 0, 2'b00, 2'b00, 0); endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'b00, 2'b00, 1); endtask
  task automatic hit_pulse(); cyc(0, 1, 0, 2'b00, 2'b00, 0); idle(); endtask

  initial begin
    model_step(1, 0, 0, 0, 0);
    // reset
    cyc(1, 0, 0, 2'b00, 2'b00, 0);
    cyc(1, 0, 0, 2'b00, 2'b00, 0);
    chk("rst_still", 8'(gra_still), 8'd1);
    // start game with left-up button
    cyc(0, 0, 0, 2'b01, 2'b00, 0);
    chk("start_state", 8'(game_state), 8'd1);
    chk("start_still", 8'(gra_still), 8'd0);
    chk("start_lives", 8'(lives), 8'd3);
    idle();
    // held hit counts once, then 12 pulses
    for (int i = 0; i < 50; i++) cyc(0, 1, 0, 2'b00, 2'b00, 0);
    idle();
    for (int i = 0; i < 12; i++) hit_pulse();
    chk("score13", {score_d1, score_d0}, 8'h13);
    for (int i = 0; i < 86; i++) hit_pulse();
    chk("score99", {score_d1, score_d0}, 8'h99);
    hit_pulse();
    chk("score_sat", {score_d1, score_d0}, 8'h99);
    // miss with 3 lives -> NEWBALL
    cyc(0, 0, 1, 2'b00, 2'b00, 0);
    chk("nb_state", 8'(game_state), 8'd2);
    chk("nb_lives", 8'(lives), 8'd2);
    chk("nb_busy", 8'(timer_busy), 8'd1);
    idle();
    cyc(0, 0, 0, 2'b00, 2'b10, 1);
    idle();
    chk("nb_early_start", 8'(game_state), 8'd2);
    ticks(DELAY_FRAMES - 1);
    chk("nb_timer_done", 8'(timer_busy), 8'd0);
    cyc(0, 0, 0, 2'b10, 2'b00, 0);
    chk("nb_resume", 8'(game_state), 8'd1);
    idle();
    // simultaneous hit and miss
    cyc(0, 1, 1, 2'b00, 2'b00, 0);
    chk("hm_lives", 8'(lives), 8'd1);
    chk("hm_score", {score_d1, score_d0}, 8'h99);
    idle();
    ticks(DELAY_FRAMES);
    cyc(0, 0, 0, 2'b00, 2'b01, 0);
    idle();
    // last life -> OVER -> NEWGAME with score shown
    cyc(0, 0, 1, 2'b00, 2'b00, 0);
    chk("over_state", 8'(game_state), 8'd3);
    chk("over_lives", 8'(lives), 8'd0);
    idle();
    ticks(DELAY_FRAMES);
    chk("over_hold", 8'(game_state), 8'd3);
    idle();
    chk("over_exit", 8'(game_state), 8'd0);
    chk("over_score", {score_d1, score_d0}, 8'h99);
    cyc(0, 0, 0, 2'b01, 2'b00, 0);
    chk("new_score", {score_d1, score_d0}, 8'h00);
    chk("new_lives", 8'(lives), 8'd3);
    idle();
    // reset mid-countdown
    hit_pulse();
    cyc(0, 0, 1, 2'b00, 2'b00, 0);
    idle();
    ticks(10);
    cyc(1, 0, 0, 2'b00, 2'b00, 1);
    chk("rstmid_state", 8'(game_state), 8'd0);
    chk("rstmid_busy", 8'(timer_busy), 8'd0);
    chk("rstmid_lives", 8'(lives), 8'd3);
    chk("rstmid_score", {score_d1, score_d0}, 8'h00);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 600) == 0, ($urandom % 3) == 0, ($urandom % 20) == 0,
          (($urandom % 8) == 0) ? 2'($urandom) : 2'b00,
          (($urandom % 8) == 0) ? 2'($urandom) : 2'b00,
          ($urandom % 3) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
